periph_reg_arbiter: RTL and testbench
=====================================

# periph_reg_arbiter

Two-requester round-robin arbiter and sequencer for the test harness's shared peripheral register port. Requester 0 is the SPI register bridge (decoded write strobes and read requests); requester 1 is the local/CPU side. The block serialises their accesses onto one peripheral bus with a ready handshake and returns read data and completion per requester. An optional timeout guards against a peripheral that never asserts ready.

## Interface
- ADDR_W, 6, register address width
- DATA_W, 32, register data width
- TIMEOUT, 15, max WAIT cycles before forced completion (only with ARB_TIMEOUT_EN); counter width = $clog2(TIMEOUT+1)
- clk  in  1  single system clock
- rstb  in  1  reset, asynchronous, active-low
- ena  in  1  global enable; when low all state, counters and outputs hold
- rN_req  in  1  (N=0,1) access request, level, held until rN_ack
- rN_we  in  1  1=write, 0=read; stable while rN_req
- rN_addr  in  ADDR_W  register address
- rN_wdata  in  DATA_W  write data
- rN_width  in  2  transaction width code (00=8b, 01=16b, 10/11=32b), passed through
- rN_ack  out  1  one-cycle completion pulse
- rN_rdata  out  DATA_W  read data, valid in rN_ack cycle, held until next ack to N
- rN_err  out  1  timeout flag, valid with rN_ack
- bus_addr  out  ADDR_W  registered address
- bus_wdata  out  DATA_W  registered write data
- bus_width  out  2  registered width
- bus_we  out  1  one-cycle write strobe
- bus_re  out  1  one-cycle read strobe
- bus_ready  in  1  peripheral completion, may assert in strobe cycle
- bus_rdata  in  DATA_W  read data, valid with bus_ready

## Operation
- FSM: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req, pick winner, latch grant, addr/wdata/width/we onto bus regs -> ISSUE. No req: stay.
- Round-robin: single requester wins unconditionally; both requesting -> the one not granted last. last_grant resets to 1, so r0 wins the first tie.
- ISSUE: bus_we or bus_re high exactly this cycle. bus_ready high -> DONE, else -> WAIT.
- WAIT: strobes low, bus regs held. bus_ready -> DONE. Timeout counter expiry -> DONE with err.
- DONE: ack pulse to granted requester; rdata captured from bus_rdata on reads; writes leave rN_rdata unchanged. Always -> IDLE. Requests are not sampled in DONE, so the requester drops req in the ack cycle without a re-issue.
- Timeout read: rdata = all-ones, err=1. Timeout write: err=1, no retry.
- bus_ready in IDLE or DONE is ignored.

## Timing
- Reset: state IDLE, all strobes/acks/err 0, bus_addr/wdata/rdata regs 0, bus_width 2'b11, last_grant 1, timeout counter 0.
- Min latency req->ack: 3 cycles (IDLE sample, ISSUE with ready, DONE). Each extra WAIT cycle adds 1.
- Back-to-back: a new grant is possible in the IDLE cycle directly after DONE, giving a 3-cycle minimum per transaction.
- Timeout counter clears on ISSUE and increments each WAIT cycle. At count==TIMEOUT: complete with err. Total WAIT cycles = TIMEOUT.
- Reset mid-transaction: immediate return to reset values; the peripheral sees no further strobe.
- ena low: frozen cycle. A strobe or ack already high stays high and is not repeated once ena returns.

## Configuration
- ARB_TIMEOUT_EN defined: timeout counter and err logic present as above.
- ARB_TIMEOUT_EN undefined: WAIT persists until bus_ready, rN_err tied 0, no counter flops, TIMEOUT unused.

## Structure
- Package periph_arb_pkg holds the arb_state_t enum (IDLE/ISSUE/WAIT/DONE) and the width-code localparams (W8, W16, W32).
- Sub-module rr_pick2: combinational 2-way round-robin pick from req[1:0] and last_grant; outputs winner and valid.

## Test plan
- r0 write addr 0x05 data 0xDEADBEEF, bus_ready in ISSUE -> bus_we one cycle with addr 0x05, r0_ack 3 cycles after req, r0_err 0.
- r1 read addr 0x12, bus_ready after 4 WAIT cycles with 0x0000A5A5 -> r1_rdata 0x0000A5A5 in r1_ack cycle, bus_re exactly one cycle.
- r0 and r1 request together, 4 times in a row -> grants alternate r0, r1, r0, r1, back-to-back with no idle gap.
- ARB_TIMEOUT_EN, TIMEOUT=15, read with no bus_ready -> ack after 15 WAIT cycles, rdata 0xFFFFFFFF, err 1. Without the macro the arbiter stays in WAIT for 100+ cycles.
- rstb low during WAIT -> all outputs at reset values at once. A new r1 request after reset wins the first tie against r0 only if r0 is idle; a true tie goes to r0.
- ena low for 5 cycles during WAIT while bus_ready stays high -> completion is delayed 5 cycles and a single ack is produced.

Source files
------------

// File: rtl/periph_arb_pkg.sv
// Shared types for the peripheral register arbiter: FSM state encoding and
// transaction width codes carried from requester to peripheral bus.
package periph_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic [1:0] W8      = 2'b00;
    localparam logic [1:0] W16     = 2'b01;
    localparam logic [1:0] W32     = 2'b10;
    // Width code the bus shows before any transaction has been issued.
    localparam logic [1:0] W_RESET = 2'b11;

endpackage

// File: rtl/periph_reg_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       winner_o,
    output logic       valid_o
);

    // NOTE: every output gets a value on every path through always_comb,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        valid_o  = |req_i;
        winner_o = (req_i == 2'b11) ? ~last_grant_i : req_i[1];
    end

endmodule

// File: rtl/periph_reg_arbiter.sv
// Round-robin arbiter/sequencer serialising two requesters onto one peripheral
// register bus. Define ARB_TIMEOUT_EN to force-complete stalled WAIT phases.
module periph_reg_arbiter
    import periph_arb_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [1:0]        r0_width,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic [1:0]        r1_width,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [1:0]        bus_width,
    output logic              bus_we,
    output logic              bus_re,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata
);

    arb_state_t        state_q;
    logic              grant_q;
    logic              last_grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic [1:0]        bus_width_q;
    logic              bus_we_q;
    logic              bus_re_q;
    logic [1:0]        ack_q;
    logic [DATA_W-1:0] r0_rdata_q;
    logic [DATA_W-1:0] r1_rdata_q;

    logic              pick_winner;
    logic              pick_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        sel_width;
    logic              done_ok;
    logic              done_tmo;
    logic [DATA_W-1:0] done_rdata;

    rr_pick2 u_pick (
        .req_i        ({r1_req, r0_req}),
        .last_grant_i (last_grant_q),
        .winner_o     (pick_winner),
        .valid_o      (pick_valid)
    );

    always_comb begin
        sel_we    = pick_winner ? r1_we    : r0_we;
        sel_addr  = pick_winner ? r1_addr  : r0_addr;
        sel_wdata = pick_winner ? r1_wdata : r0_wdata;
        sel_width = pick_winner ? r1_width : r0_width;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic [CNT_W-1:0] tmo_cnt_d;
    logic [1:0]       err_q;

    assign tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    // The WAIT cycle that brings the count up to TIMEOUT is the last one.
    assign done_tmo  = (state_q == WAIT) && !bus_ready && (tmo_cnt_d == CNT_W'(TIMEOUT));
    assign r0_err    = err_q[0];
    assign r1_err    = err_q[1];
`else
    assign done_tmo  = 1'b0;
    assign r0_err    = 1'b0;
    assign r1_err    = 1'b0;
`endif

    assign done_ok    = ((state_q == ISSUE) || (state_q == WAIT)) && bus_ready;
    assign done_rdata = done_tmo ? '1 : bus_rdata;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_width_q  <= W_RESET;
            bus_we_q     <= 1'b0;
            bus_re_q     <= 1'b0;
            ack_q        <= 2'b00;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            err_q        <= 2'b00;
`endif
        end else if (ena) begin
            // Strobes, acks and err are single-cycle pulses unless set below.
            bus_we_q <= 1'b0;
            bus_re_q <= 1'b0;
            ack_q    <= 2'b00;
`ifdef ARB_TIMEOUT_EN
            err_q    <= 2'b00;
            if (state_q == ISSUE) begin
                tmo_cnt_q <= '0;
            end else if (state_q == WAIT) begin
                tmo_cnt_q <= tmo_cnt_d;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q      <= pick_winner;
                        last_grant_q <= pick_winner;
                        we_q         <= sel_we;
                        bus_addr_q   <= sel_addr;
                        bus_wdata_q  <= sel_wdata;
                        bus_width_q  <= sel_width;
                        bus_we_q     <= sel_we;
                        bus_re_q     <= !sel_we;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (done_ok || done_tmo) begin
                        ack_q <= grant_q ? 2'b10 : 2'b01;
`ifdef ARB_TIMEOUT_EN
                        err_q <= done_tmo ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
`endif
                        if (!we_q) begin
                            if (grant_q) begin
                                r1_rdata_q <= done_rdata;
                            end else begin
                                r0_rdata_q <= done_rdata;
                            end
                        end
                        state_q <= DONE;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_width = bus_width_q;
    assign bus_we    = bus_we_q;
    assign bus_re    = bus_re_q;
    assign r0_ack    = ack_q[0];
    assign r1_ack    = ack_q[1];
    assign r0_rdata  = r0_rdata_q;
    assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_periph_reg_arbiter.sv
// Directed self-checking bench for periph_reg_arbiter: a vector table of single
// transactions plus hand-written round-robin, freeze, timeout and reset cases.
module tb_periph_reg_arbiter;
    import periph_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rstb;
    logic        ena;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [5:0]  r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic [1:0]  r0_width, r1_width;
    logic        r0_ack, r0_err, r1_ack, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic [5:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [1:0]  bus_width;
    logic        bus_we, bus_re, bus_ready;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    periph_reg_arbiter #(.ADDR_W(6), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rstb(rstb), .ena(ena),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_width(r0_width), .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_width(r1_width), .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_width(bus_width),
        .bus_we(bus_we), .bus_re(bus_re), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int          id;
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        int          nwait;
        logic [31:0] bus_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ack_of(input int id);
        return (id == 0) ? r0_ack : r1_ack;
    endfunction

    function automatic logic err_of(input int id);
        return (id == 0) ? r0_err : r1_err;
    endfunction

    function automatic logic [31:0] rdata_of(input int id);
        return (id == 0) ? r0_rdata : r1_rdata;
    endfunction

    task automatic drive(input int id, input logic req, input logic we, input logic [5:0] addr,
                         input logic [31:0] wdata, input logic [1:0] width);
        if (id == 0) begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_width = width;
        end else begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_width = width;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_strobes"}, {30'd0, bus_we, bus_re}, 32'd0);
        check({tag, "_acks"}, {30'd0, r0_ack, r1_ack}, 32'd0);
        check({tag, "_errs"}, {30'd0, r0_err, r1_err}, 32'd0);
        check({tag, "_bus_addr"}, {26'd0, bus_addr}, 32'd0);
        check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
        check({tag, "_bus_width"}, {30'd0, bus_width}, 32'd3);
        check({tag, "_r0_rdata"}, r0_rdata, 32'd0);
        check({tag, "_r1_rdata"}, r1_rdata, 32'd0);
    endtask

    // One transaction from a lone requester; ready arrives in the last of nwait WAIT cycles.
    task automatic run_txn(input vec_t v);
        drive(v.id, 1'b1, v.we, v.addr, v.wdata, v.width);
        bus_ready = 1'b0;
        step();
        check("issue_we", {31'd0, bus_we}, {31'd0, v.we});
        check("issue_re", {31'd0, bus_re}, {31'd0, !v.we});
        check("issue_addr", {26'd0, bus_addr}, {26'd0, v.addr});
        check("issue_width", {30'd0, bus_width}, {30'd0, v.width});
        if (v.we) check("issue_wdata", bus_wdata, v.wdata);
        for (int k = 0; k <= v.nwait; k++) begin
            bus_ready = (k == v.nwait);
            bus_rdata = v.bus_rd;
            step();
            if (k < v.nwait) begin
                check("wait_strobe", {31'd0, bus_we | bus_re}, 32'd0);
                check("wait_ack", {31'd0, r0_ack | r1_ack}, 32'd0);
            end
        end
        check("done_ack", {31'd0, ack_of(v.id)}, 32'd1);
        check("done_ack_other", {31'd0, ack_of(1 - v.id)}, 32'd0);
        check("done_rdata", rdata_of(v.id), v.exp_rdata);
        check("done_err", {31'd0, err_of(v.id)}, 32'd0);
        drive(v.id, 1'b0, v.we, v.addr, v.wdata, v.width);
        bus_ready = 1'b0;
        step();
        check("ack_clear", {31'd0, r0_ack | r1_ack}, 32'd0);
    endtask

    initial begin
        int exp_w;
        int cnt;
        vec_t v;

        vecs[0] = '{0, 1'b1, 6'h05, 32'hDEADBEEF, W32, 0, 32'h12345678, 32'h00000000};
        vecs[1] = '{1, 1'b0, 6'h12, 32'h00000000, W16, 4, 32'h0000A5A5, 32'h0000A5A5};
        vecs[2] = '{0, 1'b0, 6'h3F, 32'h00000000, W8,  0, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[3] = '{1, 1'b1, 6'h00, 32'h11223344, 2'b11, 2, 32'hFFFF0000, 32'h0000A5A5};
        vecs[4] = '{0, 1'b1, 6'h2A, 32'h55AA55AA, W16, 1, 32'h0BADF00D, 32'hCAFEF00D};
        vecs[5] = '{1, 1'b0, 6'h01, 32'h00000000, W32, 0, 32'h87654321, 32'h87654321};

        rstb = 1'b0; ena = 1'b1; bus_ready = 1'b0; bus_rdata = '0;
        drive(0, 1'b0, 1'b0, 6'h00, 32'h0, W8);
        drive(1, 1'b0, 1'b0, 6'h00, 32'h0, W8);
        step();
        step();
        check_reset("reset");
        rstb = 1'b1;
        step();

        foreach (vecs[i]) run_txn(vecs[i]);

        // Simultaneous requests: the acked side re-requests at once, so every IDLE is a tie.
        exp_w = 0;
        drive(0, 1'b1, 1'b0, 6'h10, 32'h0, W32);
        drive(1, 1'b1, 1'b0, 6'h20, 32'h0, W32);
        bus_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            bus_rdata = 32'h100 + r;
            step();
            check("rr_re", {31'd0, bus_re}, 32'd1);
            check("rr_addr", {26'd0, bus_addr}, (exp_w == 1) ? 32'h20 : 32'h10);
            step();
            check("rr_ack", {31'd0, ack_of(exp_w)}, 32'd1);
            check("rr_ack_other", {31'd0, ack_of(1 - exp_w)}, 32'd0);
            check("rr_rdata", rdata_of(exp_w), 32'h100 + r);
            drive(exp_w, 1'b0, 1'b0, (exp_w == 1) ? 6'h20 : 6'h10, 32'h0, W32);
            step();
            if (r < 3) begin
                drive(exp_w, 1'b1, 1'b0, (exp_w == 1) ? 6'h20 : 6'h10, 32'h0, W32);
            end else begin
                r0_req = 1'b0;
                r1_req = 1'b0;
            end
            exp_w = 1 - exp_w;
        end
        bus_ready = 1'b0;
        step();

        // Freeze during WAIT with ready already high: completion slips by the frozen cycles.
        drive(0, 1'b1, 1'b0, 6'h0C, 32'h0, W16);
        step();
        check("ena_issue_re", {31'd0, bus_re}, 32'd1);
        step();
        bus_ready = 1'b1; bus_rdata = 32'h5A5A0F0F; ena = 1'b0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            cnt += int'(r0_ack) + int'(bus_re);
        end
        check("ena_frozen_activity", cnt, 0);
        check("ena_addr_held", {26'd0, bus_addr}, 32'h0C);
        ena = 1'b1;
        step();
        check("ena_ack", {31'd0, r0_ack}, 32'd1);
        check("ena_rdata", r0_rdata, 32'h5A5A0F0F);
        r0_req = 1'b0; bus_ready = 1'b0;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            cnt += int'(r0_ack);
        end
        check("ena_single_ack", cnt, 0);

`ifdef ARB_TIMEOUT_EN
        drive(1, 1'b1, 1'b0, 6'h07, 32'h0, W32);
        step();
        check("tmo_issue_re", {31'd0, bus_re}, 32'd1);
        cnt = 0;
        for (int j = 0; j < 15; j++) begin
            step();
            cnt += int'(r1_ack);
        end
        check("tmo_early_ack", cnt, 0);
        step();
        check("tmo_ack", {31'd0, r1_ack}, 32'd1);
        check("tmo_err", {31'd0, r1_err}, 32'd1);
        check("tmo_rdata", r1_rdata, 32'hFFFFFFFF);
        r1_req = 1'b0;
        step();
        check("tmo_err_clear", {31'd0, r1_err}, 32'd0);
        drive(0, 1'b1, 1'b1, 6'h08, 32'h00000001, W8);
        step();
        for (int j = 0; j < 15; j++) step();
        step();
        check("tmo_wr_ack", {31'd0, r0_ack}, 32'd1);
        check("tmo_wr_err", {31'd0, r0_err}, 32'd1);
        check("tmo_wr_rdata_kept", r0_rdata, 32'h5A5A0F0F);
        r0_req = 1'b0;
        step();
`else
        drive(1, 1'b1, 1'b0, 6'h07, 32'h0, W32);
        step();
        check("stall_issue_re", {31'd0, bus_re}, 32'd1);
        cnt = 0;
        for (int j = 0; j < 120; j++) begin
            step();
            cnt += int'(r1_ack) + int'(r1_err);
        end
        check("stall_no_ack", cnt, 0);
        bus_ready = 1'b1; bus_rdata = 32'h13579BDF;
        step();
        check("stall_ack", {31'd0, r1_ack}, 32'd1);
        check("stall_rdata", r1_rdata, 32'h13579BDF);
        r1_req = 1'b0; bus_ready = 1'b0;
        step();
`endif

        // Reset while stalled in WAIT: outputs return to reset values without a clock edge.
        drive(1, 1'b1, 1'b0, 6'h33, 32'h0, W16);
        step();
        step();
        step();
        rstb = 1'b0;
        #1;
        check_reset("rst_mid");
        r1_req = 1'b0;
        step();
        rstb = 1'b1;
        step();
        check("rst_no_strobe", {31'd0, bus_we | bus_re}, 32'd0);
        v = '{1, 1'b0, 6'h21, 32'h0, W32, 0, 32'hBEEF0001, 32'hBEEF0001};
        run_txn(v);

        // Fresh reset then a true tie: r0 must win first.
        rstb = 1'b0;
        step();
        rstb = 1'b1;
        drive(0, 1'b1, 1'b0, 6'h0A, 32'h0, W32);
        drive(1, 1'b1, 1'b0, 6'h0B, 32'h0, W32);
        bus_ready = 1'b1; bus_rdata = 32'h00000A0A;
        step();
        check("tie_first_addr", {26'd0, bus_addr}, 32'h0A);
        step();
        check("tie_first_ack", {30'd0, r1_ack, r0_ack}, 32'd1);
        check("tie_first_rdata", r0_rdata, 32'h00000A0A);
        r0_req = 1'b0; bus_rdata = 32'h00000B0B;
        step();
        step();
        check("tie_second_addr", {26'd0, bus_addr}, 32'h0B);
        step();
        check("tie_second_ack", {30'd0, r1_ack, r0_ack}, 32'd2);
        check("tie_second_rdata", r1_rdata, 32'h00000B0B);
        r1_req = 1'b0; bus_ready = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
